alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; SHALL be a power of two ≥ 8; shift amount width SA_W = log2(DATA_W).
REQ-002 Port: clk  input  1  rising-edge clock for the output register stage.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: a  input  DATA_W  operand A.
REQ-005 Port: b  input  DATA_W  operand B; b[SA_W-1:0] is the shift amount.
REQ-006 Port: opr  input  4  operation select, {funct7[5], funct3} style.
REQ-007 Port: in_valid  input  1  qualifies a/b/opr for capture into the register stage.
REQ-008 Port: result  output  DATA_W  combinational result.
REQ-009 Port: illegal  output  1  combinational; high for an unsupported opr code.
REQ-010 Port: flags  output  4  combinational {neg, zero, carry, ovf}.
REQ-011 Port: result_q  output  DATA_W  registered result.
REQ-012 Port: flags_q  output  4  registered flags.
REQ-013 Port: out_valid  output  1  registered in_valid.

Function
REQ-014 result SHALL be purely combinational from a, b and opr, settling within the same delta cycle with no clock dependency.
REQ-015 opr 0000 ADD: a+b modulo 2^DATA_W.
REQ-016 opr 1000 SUB: a-b modulo 2^DATA_W.
REQ-017 opr 0001 SLL: a << b[SA_W-1:0], zero fill.
REQ-018 opr 0010 SLT: 1 if signed(a) < signed(b), else 0, zero-extended.
REQ-019 opr 0011 SLTU: 1 if unsigned(a) < unsigned(b), else 0.
REQ-020 opr 0100 XOR: a ^ b.
REQ-021 opr 0101 SRL: a >> b[SA_W-1:0], zero fill.
REQ-022 opr 1101 SRA: a >>> b[SA_W-1:0], sign fill from a[DATA_W-1].
REQ-023 opr 0110 OR: a | b.
REQ-024 opr 0111 AND: a & b.
REQ-025 Any other opr: result = 0 and illegal = 1; illegal = 0 for the ten legal codes.
REQ-026 Shift amounts SHALL use only b[SA_W-1:0]; upper bits of b SHALL be ignored.
REQ-027 The register stage SHALL use one cycle of latency: on each rising clk, out_valid <= in_valid; when in_valid = 1, result_q <= result and flags_q <= flags; otherwise result_q and flags_q SHALL hold.

Reset
REQ-028 rst_n low SHALL asynchronously clear result_q, flags_q and out_valid to 0.
REQ-029 Combinational outputs (result, illegal, flags) SHALL be unaffected by rst_n.
REQ-030 Release of rst_n SHALL take effect on the first rising clk edge at which rst_n is high; an in_valid asserted on that edge SHALL be captured.

Configuration
REQ-031 With macro ALU_FLAGS_EN defined: zero = (result == 0); neg = result[DATA_W-1]; carry = carry-out for ADD, and no-borrow (a >= b unsigned) for SUB, else 0; ovf = signed overflow for ADD/SUB, else 0.
REQ-032 Without ALU_FLAGS_EN: flags and flags_q SHALL be driven constant 0, and no flag logic is synthesized.

Structure
REQ-033 A shared package alu_pkg SHALL hold the opr encodings as a 4-bit enum (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND) and the flag bit-index constants.
REQ-034 The combinational datapath SHALL be a single sub-module alu_core; alu wraps it with the register stage.

Verification
REQ-035 ADD/SUB: a=10, b=5, opr=0000 -> result=15; opr=1000 -> result=5.
REQ-036 Compares: a=0xFFFFFFFF, b=1, opr=0010 -> result=1; opr=0011 -> result=0.
REQ-037 Shifts: a=1, b=3, opr=0001 -> 8; a=8, b=3, opr=0101 -> 1; a=-8, b=2, opr=1101 -> 0xFFFFFFFE; a=1, b=0x23, opr=0001 -> 8.
REQ-038 Logic ops: a=0xF0F0F0F0, b=0x0F0F0F0F, XOR -> 0xFFFFFFFF; a=0xF0F00000, b=0x0000F0F0, OR -> 0xF0F0F0F0; a=0xFF00FF00, b=0x0F0F0F0F, AND -> 0x0F000F00.
REQ-039 Illegal opcode and flags: opr=1111 -> result=0, illegal=1; with ALU_FLAGS_EN, a=0x7FFFFFFF, b=1, ADD -> flags={1,0,0,1}; a=5, b=5, SUB -> flags={0,1,1,0}.
REQ-040 Register stage and reset: drive in_valid=1 with ADD 10+5 -> one edge later result_q=15 and out_valid=1; in_valid=0 -> result_q holds 15 and out_valid=0; assert rst_n=0 between edges -> result_q=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU slice.
//   - alu_op_e : 4-bit operation encoding, {funct7[5], funct3} style
//   - FLAG_*   : bit positions inside the 4-bit flags vector {neg, zero, carry, ovf}
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;
  localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b     : operands (b[SA_W-1:0] is the shift amount)
//   opr      : operation select (alu_op_e encoding)
//   result   : operation result
//   illegal  : high for an unsupported opr code
//   flags    : {neg, zero, carry, ovf}; only computed when ALU_FLAGS_EN
//              is defined, otherwise tied to zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opr,
  output logic [DATA_W-1:0] result,
  output logic              illegal,
  output logic [FLAG_W-1:0] flags
);

  localparam int SA_W = $clog2(DATA_W);

  logic              is_sub;
  logic [SA_W-1:0]   sa;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;

  // One adder serves ADD and SUB: a + ~b + 1 for subtraction.
  assign is_sub = (opr == ALU_SUB);
  assign sa     = b[SA_W-1:0];
  assign b_eff  = is_sub ? ~b : b;

`ifdef ALU_FLAGS_EN
  logic cout;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
`else
  assign sum = a + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
`endif

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opr)
      ALU_ADD,
      ALU_SUB:  result = sum;
      ALU_SLL:  result = a << sa;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> sa;
      ALU_SRA:  result = $unsigned($signed(a) >>> sa);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  illegal = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic arith;
  assign arith = (opr == ALU_ADD) || is_sub;

  always_comb begin
    flags             = '0;
    flags[FLAG_NEG]   = result[DATA_W-1];
    flags[FLAG_ZERO]  = (result == '0);
    // For SUB the adder carry-out equals "no borrow", i.e. a >= b unsigned.
    flags[FLAG_CARRY] = arith & cout;
    // Overflow: operands (b after inversion for SUB) share a sign that the sum lacks.
    flags[FLAG_OVF]   = arith & (a[DATA_W-1] == b_eff[DATA_W-1])
                              & (sum[DATA_W-1] != a[DATA_W-1]);
  end
`else
  assign flags = '0;
`endif

endmodule

// File: rtl/alu.sv
// alu: combinational ALU (alu_core) plus a one-cycle output register stage.
//   clk, rst_n       : clock, asynchronous active-low reset (register stage only)
//   a, b, opr        : operands and operation select
//   in_valid         : qualifies a/b/opr for capture
//   result, illegal, flags : combinational outputs, independent of reset
//   result_q, flags_q, out_valid : registered outputs
// Optional feature macro: ALU_FLAGS_EN (flag generation; flags are zero otherwise).
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opr,
  input  logic              in_valid,
  output logic [DATA_W-1:0] result,
  output logic              illegal,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] result_q,
  output logic [3:0]        flags_q,
  output logic              out_valid
);

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a       (a),
    .b       (b),
    .opr     (opr),
    .result  (result),
    .illegal (illegal),
    .flags   (flags)
  );

  logic [DATA_W-1:0] res_q, res_d;
  logic              vld_q, vld_d;

  // Hold the captured result whenever in_valid is low.
  assign res_d = in_valid ? result : res_q;
  assign vld_d = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign result_q  = res_q;
  assign out_valid = vld_q;

`ifdef ALU_FLAGS_EN
  logic [3:0] flg_q, flg_d;
  assign flg_d = in_valid ? flags : flg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flg_q <= '0;
    else        flg_q <= flg_d;
  end

  assign flags_q = flg_q;
`else
  assign flags_q = '0;
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu (DATA_W = 32).
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [3:0]  opr;
  logic        in_valid;
  logic [31:0] result, result_q;
  logic        illegal, out_valid;
  logic [3:0]  flags, flags_q;

  int n_chk  = 0;
  int n_fail = 0;

  alu #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .opr       (opr),
    .in_valid  (in_valid),
    .result    (result),
    .illegal   (illegal),
    .flags     (flags),
    .result_q  (result_q),
    .flags_q   (flags_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    opr = o; a = x; b = y;
    #1;
  endtask

  task automatic vec(input string tag, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_res, input logic exp_ill);
    apply(o, x, y);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    apply(4'b0000, 32'd10, 32'd5);
    #11;
    // Reset state, and combinational path alive during reset
    check("rst.result_q",  result_q, 32'd0);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.flags_q",   {28'b0, flags_q}, 32'd0);
    check("rst.comb_add",  result, 32'd15);

    // Release between edges, capture ADD on the first edge with rst_n high
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1;
    apply(4'b0000, 32'd10, 32'd5);
    @(posedge clk); #1;
    check("reg.result_q",  result_q, 32'd15);
    check("reg.out_valid", {31'b0, out_valid}, 32'd1);

    // Hold when in_valid low
    @(negedge clk);
    in_valid = 1'b0;
    apply(4'b0000, 32'd1, 32'd1);
    @(posedge clk); #1;
    check("hold.result_q",  result_q, 32'd15);
    check("hold.out_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset between edges
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #2;
    check("pre_rst.result_q", result_q, 32'd2);
    rst_n = 1'b0; #1;
    check("async.result_q",  result_q, 32'd0);
    check("async.out_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;

    // Combinational vectors
    vec("add",   4'b0000, 32'd10, 32'd5, 32'd15, 1'b0);
    vec("sub",   4'b1000, 32'd10, 32'd5, 32'd5, 1'b0);
    vec("subwr", 4'b1000, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
    vec("addwr", 4'b0000, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0);
    vec("slt",   4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    vec("sltu",  4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    vec("sltu1", 4'b0011, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0);
    vec("sll",   4'b0001, 32'd1, 32'd3, 32'd8, 1'b0);
    vec("srl",   4'b0101, 32'd8, 32'd3, 32'd1, 1'b0);
    vec("sra",   4'b1101, 32'hFFFFFFF8, 32'd2, 32'hFFFFFFFE, 1'b0);
    vec("sllhi", 4'b0001, 32'd1, 32'h23, 32'd8, 1'b0);
    vec("sll31", 4'b0001, 32'd1, 32'd31, 32'h80000000, 1'b0);
    vec("srahi", 4'b1101, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    vec("srlhi", 4'b0101, 32'h80000000, 32'hFFFFFFFF, 32'd1, 1'b0);
    vec("xor",   4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
    vec("or",    4'b0110, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1'b0);
    vec("and",   4'b0111, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0);
    vec("ill_f", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
    vec("ill_9", 4'b1001, 32'd10, 32'd5, 32'd0, 1'b1);

    // Flags
    apply(4'b0000, 32'h7FFFFFFF, 32'd1);
`ifdef ALU_FLAGS_EN
    check("flg.add_ovf", {28'b0, flags}, 32'b1001);
`else
    check("flg.add_off", {28'b0, flags}, 32'b0000);
`endif
    apply(4'b1000, 32'd5, 32'd5);
`ifdef ALU_FLAGS_EN
    check("flg.sub_eq", {28'b0, flags}, 32'b0110);
`else
    check("flg.sub_off", {28'b0, flags}, 32'b0000);
`endif
    // Registered flags: capture the SUB 5-5 flags
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("reg2.result_q", result_q, 32'd0);
`ifdef ALU_FLAGS_EN
    check("reg2.flags_q", {28'b0, flags_q}, 32'b0110);
`else
    check("reg2.flags_q", {28'b0, flags_q}, 32'b0000);
`endif
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
